// File: rtl/arb_pkg.sv
// arb_pkg: shared state type and index-width helper for the round-robin burst arbiter
package arb_pkg;
  typedef enum logic {IDLE, LOCKED} arb_state_e;
  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotate-priority scan returning the first set mask bit at or after ptr
module rr_pick #(
  parameter int N = 4,
  parameter int IDXW = 2
) (
  input  logic [N-1:0]    mask,
  input  logic [IDXW-1:0] ptr,
  output logic            any,
  output logic [IDXW-1:0] idx
);
  logic [2*N-1:0] rot;
  int s;
  assign rot = {mask, mask} >> ptr;
  // scan downward so the lowest rotated offset (closest to ptr) wins
  always_comb begin
    any = 1'b0;
    idx = '0;
    s = 0;
    for (int k = N - 1; k >= 0; k--)
      if (rot[k]) begin
        any = 1'b1;
        s = int'(ptr) + k;
        idx = IDXW'((s >= N) ? s - N : s);
      end
  end
endmodule

// File: rtl/rr_burst_arbiter.sv
// rr_burst_arbiter: round-robin N:1 valid/ready mux with last-flag burst locking
// and a one-entry registered output stage.
module rr_burst_arbiter
  import arb_pkg::*;
#(
  parameter int  N    = 4,
  parameter type T    = bit [7:0],
  parameter int  IDXW = idx_width(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  T     [N-1:0]    req_data,
  input  logic [N-1:0]    req_last,
  output logic            out_valid,
  input  logic            out_ready,
  output T                out_data,
  output logic            out_last,
  output logic [IDXW-1:0] out_id
);
  arb_state_e      state, state_d;
  logic [IDXW-1:0] ptr, ptr_d, owner, owner_d, pick, g;
  logic            any, lock, can_load, accept;

  rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
    .mask(req_valid),
    .ptr (ptr),
    .any (any),
    .idx (pick)
  );

  assign lock      = state == LOCKED;
  assign can_load  = !out_valid || out_ready;
  assign g         = lock ? owner : pick;
  // a locked owner sees ready even with valid low, so the burst resumes with no re-arbitration
  assign req_ready = (can_load && (lock || any)) ? N'(1) << g : '0;
  assign accept    = req_valid[g] && req_ready[g];

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    owner_d = owner;
    if (accept && req_last[g]) begin
      state_d = IDLE;
      ptr_d   = (g == IDXW'(N - 1)) ? '0 : g + 1'b1;
    end else if (accept) begin
      state_d = LOCKED;
      owner_d = g;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      owner <= owner_d;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_id    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= req_data[g];
      out_last  <= req_last[g];
      out_id    <= g;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// tb_rr_burst_arbiter: scoreboard bench over three arbiter configurations (N=4/8b, N=3/17b, N=1/8b)
module tb_rr_burst_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [3:0] va, rdya, la, fa;
  bit   [3:0][7:0] da;
  logic ova, ora, ola;
  bit   [7:0] oda;
  logic [1:0] ida;

  logic [2:0] vb, rdyb, lb;
  bit   [2:0][16:0] db;
  logic ovb, orb, olb;
  bit   [16:0] odb;
  logic [1:0] idb;

  logic [0:0] vc, rdyc, lc;
  bit   [0:0][7:0] dc;
  logic ovc, orc, olc;
  bit   [7:0] odc;
  logic [0:0] idc;

  int qa[$], qb[$], qc[$];
  int pq[4][$];

  rr_burst_arbiter #(.N(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(va), .req_ready(rdya), .req_data(da), .req_last(la),
    .out_valid(ova), .out_ready(ora), .out_data(oda), .out_last(ola), .out_id(ida)
  );

  rr_burst_arbiter #(.N(3), .T(bit [16:0])) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(vb), .req_ready(rdyb), .req_data(db), .req_last(lb),
    .out_valid(ovb), .out_ready(orb), .out_data(odb), .out_last(olb), .out_id(idb)
  );

  rr_burst_arbiter #(.N(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .req_valid(vc), .req_ready(rdyc), .req_data(dc), .req_last(lc),
    .out_valid(ovc), .out_ready(orc), .out_data(odc), .out_last(olc), .out_id(idc)
  );

  task automatic chk(string tag, int obs, int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic int enc(int id, int data, logic last);
    return (id << 20) | (data << 1) | int'(last);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(int i, int data, bit last);
    pq[i].push_back((int'(last) << 8) | data);
  endtask

  task automatic drain();
    int k = 0;
    while ((qa.size() > 0 || ova || pq[0].size() > 0 || pq[1].size() > 0 ||
            pq[2].size() > 0 || pq[3].size() > 0) && k < 100) begin
      cyc();
      k++;
    end
    chk("drain", int'(k < 100), 1);
  endtask

  task automatic wait_ova();
    int k = 0;
    while (!ova && k < 20) begin
      cyc();
      k++;
    end
    chk("wait_valid", int'(ova), 1);
  endtask

  // requester models for dut_a: each presents the head of its beat queue
  initial begin
    va = '0;
    da = '0;
    la = '0;
    forever begin
      @(negedge clk);
      fa = va & rdya;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (fa[i] && pq[i].size() > 0) pq[i].delete(0);
        va[i] = pq[i].size() > 0;
        if (va[i]) begin
          da[i] = pq[i][0][7:0];
          la[i] = pq[i][0][8];
        end else begin
          da[i] = '0;
          la[i] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) if (rst_n) begin
    if (ova && ora) begin
      chk("a_pend", int'(qa.size() > 0), 1);
      if (qa.size() > 0) chk("a_beat", enc(int'(ida), int'(oda), ola), qa.pop_front());
    end
    if (ovb && orb) begin
      chk("b_pend", int'(qb.size() > 0), 1);
      if (qb.size() > 0) chk("b_beat", enc(int'(idb), int'(odb), olb), qb.pop_front());
    end
    if (ovc && orc) begin
      chk("c_pend", int'(qc.size() > 0), 1);
      if (qc.size() > 0) chk("c_beat", enc(int'(idc), int'(odc), olc), qc.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    ora = 1'b1;
    orb = 1'b1;
    orc = 1'b1;
    vb = '0; db = '0; lb = '0;
    vc = '0; dc = '0; lc = '0;
    repeat (3) cyc();
    chk("por_valid", int'(ova), 0);
    chk("por_data", int'(oda), 0);
    chk("por_id", int'(ida), 0);
    chk("por_rdy", int'(rdya), 0);
    rst_n = 1'b1;
    cyc();
    // round robin over single-beat bursts
    enq(0, 8'hA0, 1'b1);
    enq(0, 8'hA0, 1'b1);
    for (int i = 1; i < 4; i++) enq(i, 8'hA0 + i, 1'b1);
    for (int i = 0; i < 4; i++) qa.push_back(enc(i, 8'hA0 + i, 1'b1));
    qa.push_back(enc(0, 8'hA0, 1'b1));
    drain();
    // burst lock from requester 2 while 0 and 3 wait
    enq(0, 8'hB0, 1'b1);
    enq(2, 8'hC0, 1'b0);
    enq(2, 8'hC1, 1'b0);
    enq(2, 8'hC2, 1'b1);
    enq(3, 8'hD0, 1'b1);
    qa.push_back(enc(2, 8'hC0, 1'b0));
    qa.push_back(enc(2, 8'hC1, 1'b0));
    qa.push_back(enc(2, 8'hC2, 1'b1));
    qa.push_back(enc(3, 8'hD0, 1'b1));
    qa.push_back(enc(0, 8'hB0, 1'b1));
    drain();
    // backpressure holds the beat and blocks every requester
    ora = 1'b0;
    enq(1, 8'h5C, 1'b1);
    enq(2, 8'h62, 1'b1);
    qa.push_back(enc(1, 8'h5C, 1'b1));
    qa.push_back(enc(2, 8'h62, 1'b1));
    wait_ova();
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("bp_valid", int'(ova), 1);
      chk("bp_data", int'(oda), 8'h5C);
      chk("bp_id", int'(ida), 1);
      chk("bp_rdy", int'(rdya), 0);
    end
    ora = 1'b1;
    drain();
    // reset mid-burst with a held beat
    ora = 1'b0;
    enq(1, 8'h77, 1'b0);
    qa.push_back(enc(1, 8'h77, 1'b0));
    wait_ova();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(ova), 0);
    chk("mid_rst_data", int'(oda), 0);
    chk("mid_rst_id", int'(ida), 0);
    qa.delete();
    for (int i = 0; i < 4; i++) pq[i].delete();
    cyc();
    cyc();
    rst_n = 1'b1;
    ora = 1'b1;
    for (int i = 0; i < 4; i++) begin
      enq(i, 8'hE0 + i, 1'b1);
      qa.push_back(enc(i, 8'hE0 + i, 1'b1));
    end
    drain();
    // N=3 with a 17-bit payload; pointer wraps from 2 to 0
    vb = 3'b010;
    db[1] = 17'h1ABCD;
    lb = 3'b010;
    qb.push_back(enc(1, 17'h1ABCD, 1'b1));
    cyc();
    vb = '0;
    cyc();
    vb = 3'b100;
    db[2] = 17'h00022;
    lb = 3'b100;
    qb.push_back(enc(2, 17'h00022, 1'b1));
    cyc();
    vb = '0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      db[i] = 17'h10000 + 17'(i);
      qb.push_back(enc(i, 17'h10000 + i, 1'b1));
    end
    lb = 3'b111;
    vb = 3'b111;
    repeat (3) cyc();
    vb = '0;
    repeat (3) cyc();
    // N=1: owner stalls mid-burst, lock stays, burst then completes
    vc = 1'b1;
    dc[0] = 8'h11;
    lc = 1'b0;
    qc.push_back(enc(0, 8'h11, 1'b0));
    cyc();
    vc = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("c_gap_valid", int'(ovc), 0);
      chk("c_gap_rdy", int'(rdyc), 1);
    end
    vc = 1'b1;
    dc[0] = 8'h22;
    qc.push_back(enc(0, 8'h22, 1'b0));
    cyc();
    dc[0] = 8'h33;
    lc = 1'b1;
    qc.push_back(enc(0, 8'h33, 1'b1));
    cyc();
    vc = 1'b0;
    lc = 1'b0;
    repeat (2) cyc();
    chk("c_idle_rdy", int'(rdyc), 0);
    chk("a_left", qa.size(), 0);
    chk("b_left", qb.size(), 0);
    chk("c_left", qc.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
- Shares one downstream valid/ready channel between N upstream requesters, round-robin, with burst locking on a last flag.
- Payload is a type parameter; index and payload widths derive from other parameters. This exercises the parameter-dependent port types used throughout the instance/type tests.
- Sits between N producer instances and one shared consumer. The output is registered: one-entry holding register, full throughput.

Parameters:
- N, 4, number of requesters; legal range 1..64.
- T, bit [7:0], payload type parameter; any packed type.
- IDXW, (N > 1) ? $clog2(N) : 1, width of the requester index; derived, never overridden.

Ports:
- clk  input  1  clock; all state on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  N  per-requester beat valid.
- req_ready  output  N  per-requester beat accept; combinational.
- req_data  input  N x $bits(T)  packed array T [N-1:0]; element i belongs to requester i.
- req_last  input  N  per-requester end-of-burst flag.
- out_valid  output  1  holding register full.
- out_ready  input  1  downstream accept.
- out_data  output  $bits(T)  registered payload, type T.
- out_last  output  1  registered last flag.
- out_id  output  IDXW  index of the requester that sourced the beat.

Behaviour:
Reset (asynchronous assert, synchronous release on clk):
- out_valid=0, out_data=0, out_last=0, out_id=0.
- ptr=0, lock=0, owner=0, state=IDLE.
- A reset mid-burst discards the held beat and clears the lock.

Acceptance:
- can_load = !out_valid | out_ready.
- Grant g:
  - if lock=1, g=owner;
  - else g = first i with req_valid[i], scanning ptr, ptr+1, ... with wrap mod N.
- req_ready[i] = can_load & (i==g) & (lock ? 1 : req_valid[i]).
- At most one req_ready bit is set.
- req_ready never depends on req_data or req_last.
- Accept = req_valid[g] & req_ready[g].
- On accept, the holding register loads req_data[g], req_last[g], out_id=g, and out_valid=1 on the next cycle. Latency is 1 cycle.
- On out_valid & out_ready with no accept, out_valid clears.
- While out_valid & !out_ready, out_data, out_last and out_id stay stable.

State machine (IDLE / LOCKED):
- IDLE, accept with last=0: go to LOCKED, owner=g.
- IDLE, accept with last=1: stay IDLE, ptr=(g+1) mod N.
- LOCKED, accept with last=0: stay LOCKED.
- LOCKED, accept with last=1: go to IDLE, ptr=(owner+1) mod N.
- LOCKED, owner drops req_valid: stay LOCKED, grant nothing else, no timeout.

Pointer:
- Advances only on an accepted last beat.
- ptr wraps from N-1 to 0.
- With N=1: ptr stays 0 and out_id is always 0.

Simultaneous events:
- Drain and load in the same cycle: the new beat replaces the old one, out_valid stays 1, and there are no bubbles.
- All requesters valid and every beat last=1: grants rotate 0,1,...,N-1,0.

No-request case:
- If no req_valid is set and lock=0, there is no grant, and ptr and state are unchanged.

Decomposition:
- Shared package arb_pkg:
  - function idx_width(int n) returning (n > 1) ? $clog2(n) : 1;
  - typedef enum logic {IDLE, LOCKED} arb_state_e.
- Sub-module rr_pick #(N, IDXW): combinational; inputs mask N and ptr IDXW; outputs any 1 and idx IDXW. It is the rotate-priority scan.
- The top level holds the FSM, pointer, owner and holding register.

Test Plan:
1. Reset check: N=4, T=bit[7:0], assert rst_n=0 mid-operation with out_valid=1 -> out_valid=0, out_data=0, out_id=0 immediately; after release the first grant goes to requester 0.
2. Round robin: all four requesters valid with single-beat bursts (last=1), data 8'hA0+i, out_ready=1 -> out_id sequence 0,1,2,3,0; one beat per cycle; out_data A0,A1,A2,A3,A0.
3. Burst lock: requester 2 sends a 3-beat burst (last on beat 3) while requesters 0 and 3 are valid -> three consecutive beats with out_id=2; the next grant is 3, then 0.
4. Backpressure: out_ready=0 for 5 cycles with out_valid=1, data 8'h5C -> out_data holds 5C; req_ready all 0; no pointer change.
5. Type parameter: N=3, T=bit[16:0], IDXW=2, data 17'h1ABCD on requester 1 -> out_data=17'h1ABCD, out_id=2'd1; ptr wraps from 2 to 0.
6. Degenerate case: N=1, owner drops valid mid-burst for 2 cycles -> no output; lock held; the burst completes when valid returns; out_id=0 throughout.
